// File: rtl/manta_pkg.sv
// Definitions shared by the block-RAM fifo and its readout controller.
package manta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int FIFO_READ_LATENCY = 3;

endpackage

// File: rtl/readout_skid_fifo.sv
// Small register-based FIFO that catches words arriving from the fifo read pipeline.
module readout_skid_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

`ifndef SYNTHESIS
    // The upstream credit scheme must never let a word arrive with no room for it.
    always @(posedge clk) begin
        if (!rst && !clear) assert (!(push && full && !do_pop));
    end
`endif

endmodule

// File: rtl/fifo_readout_ctrl.sv
// Reads words out of the block-RAM fifo and presents them on a valid/ready stream,
// covering the fifo read latency with a credit-tracked skid buffer.
module fifo_readout_ctrl
    import manta_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = FIFO_READ_LATENCY,
    parameter int SKID_DEPTH   = 4,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] length,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] words_sent,
    input  logic               fifo_empty,
    output logic               fifo_req,
    input  logic [WIDTH-1:0]   fifo_data,
    input  logic               fifo_valid,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    input  logic               m_ready
);

    localparam int IF_W  = $clog2(READ_LATENCY + 2);
    localparam int SK_CW = $clog2(SKID_DEPTH + 1);

    state_t             state;
    state_t             state_next;
    logic [COUNT_W-1:0] length_q;
    logic [COUNT_W-1:0] issued;
    logic [IF_W-1:0]    in_flight;
    logic               drop_q;
    logic               done_q;
    logic [WIDTH-1:0]   skid_head;
    logic [SK_CW-1:0]   skid_count;
    logic               skid_empty;
    logic               abort_now;
    logic               limit_hit;
    logic               launch;
    logic               push;
    logic               pop;
    logic [31:0]        credit_used;

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign launch    = (state == IDLE) && start;
    assign abort_now = abort && busy;
    assign limit_hit = (length_q != '0) && (issued == length_q);
    assign m_valid   = !skid_empty && !drop_q;
    assign m_data    = m_valid ? skid_head : '0;
    assign pop       = m_valid && m_ready;
    assign push      = fifo_valid && !drop_q && !abort_now;

    // A word popped this cycle frees its slot before any newly issued word can land,
    // which is what lets the loop sustain one word per cycle.
    assign credit_used = 32'(in_flight) + 32'(skid_count) - 32'(pop);
    assign fifo_req    = (state == DRAIN) && !abort && !fifo_empty && !limit_hit &&
                         (credit_used < 32'(SKID_DEPTH));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRAIN;
            DRAIN:   if (abort || limit_hit) state_next = FLUSH;
            FLUSH:   if (in_flight == '0 && skid_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            in_flight  <= '0;
            issued     <= '0;
            words_sent <= '0;
        end else begin
            state  <= state_next;
            done_q <= (state == FLUSH) && (state_next == IDLE);

            if (state == IDLE)  drop_q <= 1'b0;
            else if (abort_now) drop_q <= 1'b1;

            case ({fifo_req, fifo_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase

            if (launch)        issued <= '0;
            else if (fifo_req) issued <= issued + 1'b1;

            if (launch)   words_sent <= '0;
            else if (pop) words_sent <= words_sent + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (launch) length_q <= length;
    end

    readout_skid_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (abort_now),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .head      (skid_head),
        .count     (skid_count),
        .empty     (skid_empty)
    );

endmodule

// File: tb/tb_fifo_readout_ctrl.sv
// Directed/randomized bench for fifo_readout_ctrl with a queue-based fifo and stream model.
module tb_fifo_readout_ctrl;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 16;
    localparam int LAT     = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [COUNT_W-1:0] length = '0;
    logic               abort = 1'b0;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] words_sent;
    logic               fifo_empty = 1'b1;
    logic               fifo_req;
    logic [WIDTH-1:0]   fifo_data = '0;
    logic               fifo_valid = 1'b0;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic               m_ready = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    // fifo model: stored words, read pipeline, request count
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             pv [LAT];
    logic [WIDTH-1:0] pd [LAT];
    logic             nv;
    logic [WIDTH-1:0] nd;
    int               req_cnt = 0;

    // stream observation
    int               delivered = 0;
    int               done_cnt  = 0;
    logic             hold_v = 1'b0;
    logic [WIDTH-1:0] hold_d = '0;

    fifo_readout_ctrl #(
        .WIDTH        (WIDTH),
        .READ_LATENCY (LAT),
        .SKID_DEPTH   (4),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .fifo_empty (fifo_empty),
        .fifo_req   (fifo_req),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Fifo with fixed read latency: a request in cycle c yields data valid in cycle c+LAT.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            for (int i = 0; i < LAT; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
            fifo_valid <= 1'b0;
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            nv = 1'b0;
            nd = '0;
            if (fifo_req) begin
                req_cnt++;
                nv = 1'b1;
                if (fq.size() > 0) nd = fq.pop_front();
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = nv;
            pd[0] = nd;
            fifo_valid <= pv[LAT-1];
            fifo_data  <= pd[LAT-1];
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream monitor: in-order delivery, hold-while-stalled, no request into an empty fifo.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (fifo_req) check("req_while_empty", 32'(fifo_empty), 0);
            if (hold_v) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(hold_d));
            end
            if (m_valid && m_ready) begin
                delivered++;
                if (exp_q.size() == 0) check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                else check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            if (done) done_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; length = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic fifo_write(input int n);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = WIDTH'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic launch(input int len);
        start = 1'b1;
        length = COUNT_W'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    int d0, dc, r0, k, pushed, n;

    initial begin
        reset_all();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fifo_req", 32'(fifo_req), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_words_sent", 32'(words_sent), 0);
        check("rst_m_data", 32'(m_data), 0);

        // 1: counted burst of 10 at full rate
        fifo_write(10);
        tick();
        m_ready = 1'b1;
        d0 = delivered; dc = done_cnt;
        launch(10);
        check("t1_busy", 32'(busy), 1);
        k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        check("t1_first_valid_lat", 32'(k), 4);
        wait_idle("t1_idle", 100);
        tick();
        check("t1_delivered", 32'(delivered - d0), 10);
        check("t1_words_sent", 32'(words_sent), 10);
        check("t1_done_pulses", 32'(done_cnt - dc), 1);
        check("t1_exp_left", 32'(exp_q.size()), 0);

        // 2: length 8 out of 20 with toggling ready
        reset_all();
        fifo_write(20);
        tick();
        d0 = delivered; dc = done_cnt;
        m_ready = 1'b1;
        launch(8);
        n = 0;
        while (busy && n < 200) begin
            m_ready = ~m_ready;
            tick();
            n++;
        end
        check("t2_idle", 32'(busy), 0);
        m_ready = 1'b0;
        tick();
        check("t2_delivered", 32'(delivered - d0), 8);
        check("t2_words_sent", 32'(words_sent), 8);
        check("t2_fifo_left", 32'(fq.size()), 12);
        check("t2_done_pulses", 32'(done_cnt - dc), 1);

        // 3: long stall, credits cap issues at the skid depth
        reset_all();
        fifo_write(30);
        tick();
        d0 = delivered; r0 = req_cnt;
        launch(20);
        repeat (50) tick();
        check("t3_issues_stalled", 32'(req_cnt - r0), 4);
        check("t3_m_valid_held", 32'(m_valid), 1);
        check("t3_none_delivered", 32'(delivered - d0), 0);
        m_ready = 1'b1;
        wait_idle("t3_idle", 200);
        tick();
        check("t3_delivered", 32'(delivered - d0), 20);
        check("t3_words_sent", 32'(words_sent), 20);

        // 4: continuous drain of 100 words written in random bursts, random ready
        reset_all();
        tick();
        d0 = delivered; dc = done_cnt;
        launch(0);
        pushed = 0;
        n = 0;
        while (!(pushed == 100 && delivered - d0 == 100) && n < 5000) begin
            if (pushed < 100 && ($urandom % 3) == 0) begin
                k = $urandom_range(1, 8);
                if (k > 100 - pushed) k = 100 - pushed;
                fifo_write(k);
                pushed += k;
            end
            m_ready = (($urandom % 4) != 0);
            tick();
            n++;
        end
        check("t4_delivered", 32'(delivered - d0), 100);
        check("t4_busy_before_abort", 32'(busy), 1);
        m_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("t4_idle", 50);
        tick();
        check("t4_done_pulses", 32'(done_cnt - dc), 1);
        check("t4_words_sent", 32'(words_sent), 100);

        // 5: abort with three reads outstanding
        reset_all();
        fifo_write(10);
        tick();
        m_ready = 1'b1;
        d0 = delivered; dc = done_cnt; r0 = req_cnt;
        launch(10);
        tick();
        tick();
        tick();
        abort = 1'b1;
        #1;
        check("t5_req_low_on_abort", 32'(fifo_req), 0);
        check("t5_issued_before_abort", 32'(req_cnt - r0), 3);
        tick();
        abort = 1'b0;
        check("t5_m_valid_after_abort", 32'(m_valid), 0);
        wait_idle("t5_idle", 50);
        tick();
        check("t5_dropped", 32'(delivered - d0), 0);
        check("t5_no_more_issues", 32'(req_cnt - r0), 3);
        check("t5_done_pulses", 32'(done_cnt - dc), 1);
        check("t5_m_valid_end", 32'(m_valid), 0);

        // 6: reset mid-burst, then a clean run
        reset_all();
        fifo_write(20);
        tick();
        m_ready = 1'b1;
        launch(20);
        repeat (8) tick();
        check("t6_mid_busy", 32'(busy), 1);
        dc = done_cnt;
        rst = 1'b1;
        tick();
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_m_valid", 32'(m_valid), 0);
        check("t6_rst_fifo_req", 32'(fifo_req), 0);
        check("t6_rst_words_sent", 32'(words_sent), 0);
        check("t6_rst_m_data", 32'(m_data), 0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("t6_no_done_on_rst", 32'(done_cnt - dc), 0);
        fifo_write(5);
        tick();
        d0 = delivered;
        launch(5);
        wait_idle("t6_idle", 100);
        tick();
        check("t6_delivered", 32'(delivered - d0), 5);
        check("t6_words_sent", 32'(words_sent), 5);
        check("t6_done_pulses", 32'(done_cnt - dc), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
